bus_master_burst: RTL and testbench

Parametrised bus master that turns queued read/write commands into bus transactions on the shared valid/ready bus.
- Runs an address phase, then 1..2^LEN_W data beats with auto-incrementing address.
- Write data comes from a streaming input; read data and completion status go to a response output.
- A per-beat timeout aborts hung transactions.
- Sits between a command source (CPU/test sequencer) and the bus fabric/slave register blocks.

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_timeout_counter.sv | 29 ++
 rtl/bus_master_burst.sv | 235 +++++++++++++++++++++++
 tb/tb_bus_master_burst.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the burst bus master: FSM state encoding,
// default bus widths and the byte stride between consecutive beats.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ADDR_PHASE = 2'd1,
        DATA_PHASE = 2'd2,
        RESP_PHASE = 2'd3
    } state_t;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 32;

    function automatic int byte_stride(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating stall counter; expired fires in the cycle that would be the
// TIMEOUT-th consecutive stalled cycle, so the master can abort on that edge.
module bus_timeout_counter #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic stall,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    // count_reg holds the number of stalled cycles already completed
    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (stall && (count_reg != LIMIT)) begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign expired = stall && (count_reg == LIMIT);

endmodule

// File: rtl/bus_master_burst.sv
// Burst bus master: accepts read/write commands, runs an address phase and
// 1..2^LEN_W data beats with incrementing address, and reports responses.
module bus_master_burst
    import bus_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error,
    output logic              rsp_last,
    input  logic              rsp_ready,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_read,
    output logic              bus_write,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_write_data,
    input  logic [DATA_W-1:0] bus_read_data
);

    localparam int BEAT_W = LEN_W + 1;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(byte_stride(DATA_W));

    state_t              state_reg, state_next;
    logic                write_reg, write_next;
    logic [ADDR_W-1:0]   base_reg, base_next;
    logic [LEN_W-1:0]    len_reg, len_next;
    logic [BEAT_W-1:0]   beat_reg, beat_next;
    logic                hold_full_reg, hold_full_next;
    logic [DATA_W-1:0]   hold_data_reg, hold_data_next;
    logic                rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0]   rsp_data_reg, rsp_data_next;
    logic                rsp_error_reg, rsp_error_next;
    logic                rsp_last_reg, rsp_last_next;
    logic                cmd_ready_reg, cmd_ready_next;
    logic                wr_ready_reg, wr_ready_next;
    logic                bus_valid_reg, bus_valid_next;
    logic                bus_read_reg, bus_read_next;
    logic                bus_write_reg, bus_write_next;
    logic [ADDR_W-1:0]   bus_addr_reg, bus_addr_next;

    logic cmd_fire, wr_fire, bus_fire, rsp_fire;
    logic stall, expired, last_beat, beats_left_next, active_next, abort;

    assign cmd_fire  = cmd_valid && cmd_ready_reg;
    assign wr_fire   = wr_valid && wr_ready_reg;
    assign bus_fire  = bus_valid_reg && bus_ready;
    assign rsp_fire  = rsp_valid_reg && rsp_ready;
    assign stall     = bus_valid_reg && !bus_ready;
    assign last_beat = (beat_reg == {1'b0, len_reg});

    // Any cycle that is not a stall (transfer, idle bus, phase change) restarts the count
    bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (!stall),
        .stall   (stall),
        .expired (expired)
    );

    always_comb begin
        state_next     = state_reg;
        write_next     = write_reg;
        base_next      = base_reg;
        len_next       = len_reg;
        beat_next      = beat_reg;
        hold_full_next = hold_full_reg;
        hold_data_next = hold_data_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_error_next = rsp_error_reg;
        rsp_last_next  = rsp_last_reg;
        abort          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cmd_fire) begin
                    write_next     = cmd_write;
                    base_next      = cmd_addr;
                    len_next       = cmd_len;
                    beat_next      = '0;
                    hold_full_next = 1'b0;
                    state_next     = ADDR_PHASE;
                end
            end
            ADDR_PHASE: begin
                if (expired) begin
                    abort = 1'b1;
                end else if (bus_fire) begin
                    state_next = DATA_PHASE;
                end
            end
            DATA_PHASE: begin
                if (write_reg) begin
                    if (wr_fire) begin
                        hold_full_next = 1'b1;
                        hold_data_next = wr_data;
                    end
                    if (bus_fire) begin
                        hold_full_next = 1'b0;
                        beat_next      = beat_reg + BEAT_W'(1);
                        if (last_beat) begin
                            state_next     = RESP_PHASE;
                            rsp_valid_next = 1'b1;
                            rsp_data_next  = '0;
                            rsp_error_next = 1'b0;
                            rsp_last_next  = 1'b1;
                        end
                    end
                end else begin
                    if (rsp_fire) begin
                        rsp_valid_next = 1'b0;
                        rsp_data_next  = '0;
                        rsp_last_next  = 1'b0;
                        if (rsp_last_reg) begin
                            state_next = IDLE;
                        end
                    end
                    if (bus_fire) begin
                        rsp_valid_next = 1'b1;
                        rsp_data_next  = bus_read_data;
                        rsp_error_next = 1'b0;
                        rsp_last_next  = last_beat;
                        beat_next      = beat_reg + BEAT_W'(1);
                    end
                end
                if (expired) begin
                    abort = 1'b1;
                end
            end
            RESP_PHASE: begin
                if (rsp_fire) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                    rsp_error_next = 1'b0;
                    rsp_last_next  = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        // A stalled bus implies the response register is empty, so no read data is lost here
        if (abort) begin
            state_next     = RESP_PHASE;
            hold_full_next = 1'b0;
            rsp_valid_next = 1'b1;
            rsp_data_next  = '0;
            rsp_error_next = 1'b1;
            rsp_last_next  = 1'b1;
        end

        // Registered outputs are derived from the state being entered
        active_next     = (state_next == ADDR_PHASE) || (state_next == DATA_PHASE);
        beats_left_next = (beat_next <= {1'b0, len_next});
        cmd_ready_next  = (state_next == IDLE);
        wr_ready_next   = (state_next == DATA_PHASE) && write_next && !hold_full_next && beats_left_next;
        bus_read_next   = active_next && !write_next;
        bus_write_next  = active_next && write_next;
        bus_addr_next   = active_next ? (base_next + ADDR_W'(beat_next) * STRIDE) : '0;

        case (state_next)
            ADDR_PHASE: bus_valid_next = 1'b1;
            DATA_PHASE: bus_valid_next = write_next ? hold_full_next
                                                    : (!rsp_valid_next && beats_left_next);
            default:    bus_valid_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            write_reg     <= 1'b0;
            base_reg      <= '0;
            len_reg       <= '0;
            beat_reg      <= '0;
            hold_full_reg <= 1'b0;
            hold_data_reg <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_error_reg <= 1'b0;
            rsp_last_reg  <= 1'b0;
            cmd_ready_reg <= 1'b0;
            wr_ready_reg  <= 1'b0;
            bus_valid_reg <= 1'b0;
            bus_read_reg  <= 1'b0;
            bus_write_reg <= 1'b0;
            bus_addr_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            write_reg     <= write_next;
            base_reg      <= base_next;
            len_reg       <= len_next;
            beat_reg      <= beat_next;
            hold_full_reg <= hold_full_next;
            hold_data_reg <= hold_data_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_error_reg <= rsp_error_next;
            rsp_last_reg  <= rsp_last_next;
            cmd_ready_reg <= cmd_ready_next;
            wr_ready_reg  <= wr_ready_next;
            bus_valid_reg <= bus_valid_next;
            bus_read_reg  <= bus_read_next;
            bus_write_reg <= bus_write_next;
            bus_addr_reg  <= bus_addr_next;
        end
    end

    assign cmd_ready      = cmd_ready_reg;
    assign wr_ready       = wr_ready_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_data       = rsp_data_reg;
    assign rsp_error      = rsp_error_reg;
    assign rsp_last       = rsp_last_reg;
    assign bus_valid      = bus_valid_reg;
    assign bus_read       = bus_read_reg;
    assign bus_write      = bus_write_reg;
    assign bus_addr       = bus_addr_reg;
    assign bus_write_data = hold_data_reg;

endmodule

// File: tb/tb_bus_master_burst.sv
// Scoreboard bench for bus_master_burst: the command model predicts bus beats
// and responses into queues, and a negedge monitor pops and compares them.
module tb_bus_master_burst;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int LEN_W   = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic              wr_valid = 1'b0, wr_ready;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rsp_valid, rsp_error, rsp_last, rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              bus_valid, bus_ready = 1'b0, bus_read, bus_write;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_write_data, bus_read_data;

    always #5 clk = ~clk;

    bus_master_burst #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
        .rsp_last(rsp_last), .rsp_ready(rsp_ready),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_read(bus_read),
        .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_write_data(bus_write_data), .bus_read_data(bus_read_data)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic              is_data;
        logic [DATA_W-1:0] data;
    } bus_item_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              err;
        logic              last;
    } rsp_item_t;

    bus_item_t         exp_bus_q[$];
    rsp_item_t         exp_rsp_q[$];
    logic [DATA_W-1:0] wr_q[$];
    int checks = 0;
    int errors = 0;
    int bus_mode = 0;   // 0 always ready, 1 random, 2 stuck low
    int rsp_mode = 0;   // 0 always ready, 1 random, 2 held low
    bit mon_en = 1'b0;

    // Slave memory: each address returns a distinct word
    function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    assign bus_read_data = bus_valid ? mem_fn(bus_addr) : '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        bus_item_t bi;
        rsp_item_t ri;
        if (mon_en && !reset) begin
            if (bus_valid && bus_ready) begin
                if (exp_bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected: transfer at addr %h, none expected", bus_addr);
                end else begin
                    bi = exp_bus_q.pop_front();
                    chk("bus_addr", 64'(bus_addr), 64'(bi.addr));
                    chk("bus_write", 64'(bus_write), 64'(bi.wr));
                    chk("bus_read", 64'(bus_read), 64'(!bi.wr));
                    if (bi.is_data && bi.wr) chk("bus_wdata", 64'(bus_write_data), 64'(bi.data));
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: data %h, none expected", rsp_data);
                end else begin
                    ri = exp_rsp_q.pop_front();
                    chk("rsp_data", 64'(rsp_data), 64'(ri.data));
                    chk("rsp_error", 64'(rsp_error), 64'(ri.err));
                    chk("rsp_last", 64'(rsp_last), 64'(ri.last));
                end
            end
            if (bus_read && bus_write) begin
                checks++; errors++;
                $display("FAIL rw_both: bus_read and bus_write both 1");
            end
        end
    end

    // Write-data source: offers queued words with random gaps, holds until accepted
    initial begin : wr_src
        bit wfire;
        forever begin
            @(negedge clk);
            wfire = wr_valid && wr_ready;
            @(posedge clk); #1;
            if (reset) begin
                wr_valid = 1'b0;
            end else begin
                if (wfire) begin
                    if (wr_q.size() > 0) wr_q.delete(0);
                    wr_valid = 1'b0;
                end
                if (!wr_valid && wr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    wr_valid = 1'b1;
                    wr_data  = wr_q[0];
                end
            end
        end
    end

    // Ready drivers; random bus_ready never stalls long enough to time out
    initial begin : ready_drv
        int zs;
        zs = 0;
        forever begin
            @(posedge clk); #1;
            case (bus_mode)
                0: bus_ready = 1'b1;
                1: begin
                    bus_ready = (zs >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
                    zs = bus_ready ? 0 : zs + 1;
                end
                default: bus_ready = 1'b0;
            endcase
            case (rsp_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = 1'($urandom_range(0, 1));
                default: rsp_ready = 1'b0;
            endcase
        end
    end

    task automatic issue(input logic wr, input logic [ADDR_W-1:0] addr, input int len,
                         input bit model, input bit use_fdata, input logic [DATA_W-1:0] fdata);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int n;
        if (model) begin
            exp_bus_q.push_back('{addr: addr, wr: wr, is_data: 1'b0, data: '0});
            for (int i = 0; i <= len; i++) begin
                a = addr + ADDR_W'(i * (DATA_W / 8));
                if (wr) begin
                    d = (use_fdata && i == 0) ? fdata : $urandom;
                    wr_q.push_back(d);
                    exp_bus_q.push_back('{addr: a, wr: 1'b1, is_data: 1'b1, data: d});
                end else begin
                    exp_bus_q.push_back('{addr: a, wr: 1'b0, is_data: 1'b1, data: '0});
                    exp_rsp_q.push_back('{data: mem_fn(a), err: 1'b0, last: (i == len)});
                end
            end
            if (wr) exp_rsp_q.push_back('{data: '0, err: 1'b0, last: 1'b1});
        end
        $display("cmd %s addr=%h len=%0d", wr ? "WR" : "RD", addr, len);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_len   = LEN_W'(len);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 200);
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_rsp_q.size() != 0 || exp_bus_q.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL done_timeout: %0d bus / %0d rsp items outstanding, required 0",
                     exp_bus_q.size(), exp_rsp_q.size());
            exp_bus_q.delete(); exp_rsp_q.delete(); wr_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin : main
        int n, vcnt;
        logic [ADDR_W-1:0] ra;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", 64'({cmd_ready, wr_ready, bus_valid, bus_read, bus_write,
                              rsp_valid, rsp_error, rsp_last, bus_addr}), 64'd0);
        chk("reset_data", {bus_write_data, rsp_data}, 64'd0);
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clk); #1;

        // Single-beat write
        bus_mode = 0; rsp_mode = 0;
        issue(1'b1, 16'h0010, 0, 1'b1, 1'b1, 32'hDEADBEEF);
        wait_done();

        // Four-beat read
        issue(1'b0, 16'h0020, 3, 1'b1, 1'b0, '0);
        wait_done();

        // Response backpressure stalls the bus after the first captured beat
        rsp_mode = 2;
        @(posedge clk); #1;
        issue(1'b0, 16'h0020, 3, 1'b1, 1'b0, '0);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rsp_seen", 64'(rsp_valid), 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_bus_valid", 64'(bus_valid), 64'd0);
            chk("bp_bus_addr", 64'(bus_addr), 64'h0024);
            @(negedge clk);
        end
        rsp_mode = 0;
        wait_done();

        // Timeout on a write whose address phase is never accepted
        bus_mode = 2;
        @(posedge clk); #1;
        exp_rsp_q.push_back('{data: '0, err: 1'b1, last: 1'b1});
        issue(1'b1, 16'h0040, 2, 1'b0, 1'b0, '0);
        vcnt = 0;
        n = 0;
        while (exp_rsp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            if (bus_valid) vcnt++;
            n++;
        end
        chk("timeout_valid_cycles", 64'(vcnt), 64'(TIMEOUT));
        chk("timeout_rsp_done", 64'(exp_rsp_q.size()), 64'd0);
        @(negedge clk);
        chk("timeout_idle", 64'({cmd_ready, bus_valid, bus_write}), 64'b100);
        bus_mode = 0;
        @(posedge clk); #1;

        // Address wrap
        issue(1'b1, 16'hFFFC, 1, 1'b1, 1'b0, '0);
        wait_done();

        // Reset in the middle of a read burst
        issue(1'b0, 16'h0080, 3, 1'b1, 1'b0, '0);
        n = 0;
        while (!(bus_valid && bus_ready && bus_addr == 16'h0084) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_beat2_seen", 64'(bus_addr), 64'h0084);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ctl", 64'({cmd_ready, wr_ready, bus_valid, bus_read, bus_write,
                                rsp_valid, rsp_error, rsp_last, bus_addr}), 64'd0);
        chk("rst_mid_data", {bus_write_data, rsp_data}, 64'd0);
        exp_bus_q.delete(); exp_rsp_q.delete(); wr_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_recover", 64'({cmd_ready, rsp_valid}), 64'b10);
        @(posedge clk); #1;

        // Randomized commands with random bus and response backpressure
        bus_mode = 1; rsp_mode = 1;
        for (int t = 0; t < 40; t++) begin
            ra = ($urandom_range(0, 5) == 0) ? 16'hFFF0 : (16'($urandom) & 16'hFFFC);
            issue(1'($urandom_range(0, 1)), ra, $urandom_range(0, 15), 1'b1, 1'b0, '0);
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
